// File: rtl/xrv1_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xrv1_mul_pkg
// Description : Shared types and helpers for the xrv1 iterative multiplier:
//               opcode encoding, FSM state encoding and per-opcode
//               operand signedness.
// Revision    : 1.0 - initial release
// ============================================================================
package xrv1_mul_pkg;

  // Opcode encoding as presented by the execution stage
  typedef enum logic [1:0] {
    MUL_OPC_MUL    = 2'b00,
    MUL_OPC_MULH   = 2'b01,
    MUL_OPC_MULHSU = 2'b10,
    MUL_OPC_MULHU  = 2'b11
  } mul_opc_e;

  // Sequencer states
  typedef enum logic [1:0] {
    MUL_ST_IDLE = 2'b00,
    MUL_ST_CALC = 2'b01,
    MUL_ST_FIX  = 2'b10,
    MUL_ST_DONE = 2'b11
  } mul_state_e;

  // rs1 is interpreted as two's complement for MULH and MULHSU
  function automatic logic mul_src0_signed(input mul_opc_e opc);
    return (opc == MUL_OPC_MULH) || (opc == MUL_OPC_MULHSU);
  endfunction

  // rs2 is interpreted as two's complement only for MULH
  function automatic logic mul_src1_signed(input mul_opc_e opc);
    return (opc == MUL_OPC_MULH);
  endfunction

  // MUL returns the low half of the product, all others the high half
  function automatic logic mul_opc_is_low(input mul_opc_e opc);
    return (opc == MUL_OPC_MUL);
  endfunction

endpackage : xrv1_mul_pkg
`default_nettype wire

// File: rtl/xrv1_mul_pp_step.sv
`default_nettype none
// ============================================================================
// Module      : xrv1_mul_pp_step
// Description : One radix-2^K step of a shift-right multiplier. The low half
//               of the accumulator holds the not-yet-consumed multiplier bits;
//               its low K bits select the partial product, which is added to
//               the high half, and the whole 2W value shifts right by K.
//               After W/K steps the accumulator holds the full 2W product.
// Revision    : 1.0 - initial release
// ============================================================================
module xrv1_mul_pp_step #(
  parameter int DATA_WIDTH_P     = 32,
  parameter int BITS_PER_CYCLE_P = 4
) (
  input  logic [2*DATA_WIDTH_P-1:0] acc_i,
  input  logic [DATA_WIDTH_P-1:0]   mcand_i,
  output logic [2*DATA_WIDTH_P-1:0] acc_o
);

  localparam int c_W = DATA_WIDTH_P;
  localparam int c_K = BITS_PER_CYCLE_P;

  logic [c_W+c_K-1:0] w_pp;
  logic [c_W+c_K-1:0] w_sum;

  // Partial product, add into the upper half, then retire K bits to the right.
  // The sum cannot overflow W+K bits: (2^W-1) + (2^W-1)*(2^K-1) < 2^(W+K).
  always_comb begin
    w_pp  = {{c_K{1'b0}}, mcand_i} * {{c_W{1'b0}}, acc_i[c_K-1:0]};
    w_sum = {{c_K{1'b0}}, acc_i[2*c_W-1:c_W]} + w_pp;
    acc_o = {w_sum, acc_i[c_W-1:c_K]};
  end

endmodule : xrv1_mul_pp_step
`default_nettype wire

// File: rtl/xrv1_mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : xrv1_mul_iter
// Description : Iterative RV32M/RV64M multiplier (MUL/MULH/MULHSU/MULHU).
//               Operands are converted to magnitudes on accept, multiplied
//               unsigned at BITS_PER_CYCLE_P bits per cycle, then the sign is
//               restored on the full double-width product. Carries an
//               instruction tag and honours a pipeline kill.
// Revision    : 1.0 - initial release
// ============================================================================
module xrv1_mul_iter #(
  parameter int DATA_WIDTH_P     = 32,
  parameter int ITAG_WIDTH_P     = 4,
  parameter int BITS_PER_CYCLE_P = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    mul_req_i,
  output logic                    mul_rdy_o,
  input  logic                    mul_kill_i,
  input  logic [1:0]              mul_opc_i,
  input  logic [DATA_WIDTH_P-1:0] mul_src0_i,
  input  logic [DATA_WIDTH_P-1:0] mul_src1_i,
  input  logic [ITAG_WIDTH_P-1:0] mul_itag_i,
  output logic                    mul_res_vld_o,
  output logic [DATA_WIDTH_P-1:0] mul_res_o,
  output logic [ITAG_WIDTH_P-1:0] mul_itag_o
);

  import xrv1_mul_pkg::*;

  localparam int c_W      = DATA_WIDTH_P;
  localparam int c_ITERS  = DATA_WIDTH_P / BITS_PER_CYCLE_P;
  localparam int c_CNT_W  = (c_ITERS > 1) ? $clog2(c_ITERS) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_ITERS - 1);

  // Sequencer
  mul_state_e r_state;
  mul_state_e w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;

  // Datapath. The low half of r_acc starts out holding the multiplier
  // magnitude and is shifted out as the product bits shift in.
  logic [c_W-1:0]   r_mcand;
  logic [2*c_W-1:0] r_acc;
  logic             r_neg;
  mul_opc_e         r_opc;
  logic [ITAG_WIDTH_P-1:0] r_itag;

  // Result-side registers
  logic [c_W-1:0]          r_res;
  logic [ITAG_WIDTH_P-1:0] r_itag_res;

  // Combinational helpers
  logic             w_accept;
  mul_opc_e         w_opc;
  logic             w_sign0;
  logic             w_sign1;
  logic [c_W-1:0]   w_mag0;
  logic [c_W-1:0]   w_mag1;
  logic [2*c_W-1:0] w_acc_step;
  logic [2*c_W-1:0] w_prod;
  logic [c_W-1:0]   w_res_sel;

  xrv1_mul_pp_step #(
    .DATA_WIDTH_P     (DATA_WIDTH_P),
    .BITS_PER_CYCLE_P (BITS_PER_CYCLE_P)
  ) u_pp_step (
    .acc_i   (r_acc),
    .mcand_i (r_mcand),
    .acc_o   (w_acc_step)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= MUL_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, handshake and result-valid decode
  always_comb begin
    w_state_nxt   = r_state;
    mul_rdy_o     = 1'b0;
    mul_res_vld_o = 1'b0;
    case (r_state)
      MUL_ST_IDLE: begin
        mul_rdy_o = 1'b1;
        if (mul_req_i) begin
          w_state_nxt = MUL_ST_CALC;
        end
      end
      MUL_ST_CALC: begin
        if (mul_kill_i) begin
          w_state_nxt = MUL_ST_IDLE;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = MUL_ST_FIX;
        end
      end
      MUL_ST_FIX: begin
        w_state_nxt = mul_kill_i ? MUL_ST_IDLE : MUL_ST_DONE;
      end
      MUL_ST_DONE: begin
        // A kill here only suppresses this result; a request in the same
        // cycle is a new operation and is still accepted.
        mul_rdy_o     = 1'b1;
        mul_res_vld_o = ~mul_kill_i;
        w_state_nxt   = mul_req_i ? MUL_ST_CALC : MUL_ST_IDLE;
      end
      default: begin
        w_state_nxt = MUL_ST_IDLE;
      end
    endcase
  end

  assign w_accept = mul_req_i & mul_rdy_o;

  // Operand conditioning: signed inputs become magnitudes plus a product sign.
  // The most negative value maps onto itself, which is the correct unsigned
  // magnitude. MUL never negates, so the low half is sign-agnostic.
  always_comb begin
    w_opc   = mul_opc_e'(mul_opc_i);
    w_sign0 = mul_src0_signed(w_opc) & mul_src0_i[c_W-1];
    w_sign1 = mul_src1_signed(w_opc) & mul_src1_i[c_W-1];
    w_mag0  = w_sign0 ? (~mul_src0_i + 1'b1) : mul_src0_i;
    w_mag1  = w_sign1 ? (~mul_src1_i + 1'b1) : mul_src1_i;
  end

  // Sign restore on the full product, then half selection
  always_comb begin
    w_prod    = r_neg ? (~r_acc + 1'b1) : r_acc;
    w_res_sel = mul_opc_is_low(r_opc) ? w_prod[c_W-1:0] : w_prod[2*c_W-1:c_W];
  end

  // Operand capture on accept and one multiply step per CALC cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt   <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
      r_neg   <= 1'b0;
      r_opc   <= MUL_OPC_MUL;
      r_itag  <= '0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_mcand <= w_mag0;
      r_acc   <= {{c_W{1'b0}}, w_mag1};
      r_neg   <= w_sign0 ^ w_sign1;
      r_opc   <= w_opc;
      r_itag  <= mul_itag_i;
    end else if (r_state == MUL_ST_CALC) begin
      r_acc   <= w_acc_step;
      r_cnt   <= r_cnt + c_CNT_W'(1);
    end
  end

  // Result and tag registers load in FIX unless the operation is killed,
  // so the outputs keep their last delivered values otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_res      <= '0;
      r_itag_res <= '0;
    end else if ((r_state == MUL_ST_FIX) && !mul_kill_i) begin
      r_res      <= w_res_sel;
      r_itag_res <= r_itag;
    end
  end

  assign mul_res_o  = r_res;
  assign mul_itag_o = r_itag_res;

endmodule : xrv1_mul_iter
`default_nettype wire

// File: tb/tb_xrv1_mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_xrv1_mul_iter
// Description : Self-checking bench for xrv1_mul_iter. Instance 0 (W=32, K=4)
//               gets directed latency/kill/reset scenarios; all instances
//               then run randomized traffic against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xrv1_mul_iter;

  localparam int NC = 6;

  function automatic int cfg_w(input int i);
    return (i >= 4) ? 64 : 32;
  endfunction

  function automatic int cfg_k(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      2:       return 2;
      3:       return 8;
      4:       return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_n(input int i);
    return cfg_w(i) / cfg_k(i);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst  [NC];
  logic          req  [NC];
  logic          kill [NC];
  logic [1:0]    opc  [NC];
  logic [63:0]   src0 [NC];
  logic [63:0]   src1 [NC];
  logic [3:0]    itag [NC];
  logic [NC-1:0] rdy;
  logic [NC-1:0] vld;
  logic [63:0]   res  [NC];
  logic [3:0]    otag [NC];

  for (genvar gi = 0; gi < NC; gi++) begin : g_dut
    localparam int W = cfg_w(gi);
    localparam int K = cfg_k(gi);
    logic [W-1:0] res_w;
    xrv1_mul_iter #(
      .DATA_WIDTH_P     (W),
      .ITAG_WIDTH_P     (4),
      .BITS_PER_CYCLE_P (K)
    ) u_dut (
      .clk_i         (clk),
      .rst_i         (rst[gi]),
      .mul_req_i     (req[gi]),
      .mul_rdy_o     (rdy[gi]),
      .mul_kill_i    (kill[gi]),
      .mul_opc_i     (opc[gi]),
      .mul_src0_i    (src0[gi][W-1:0]),
      .mul_src1_i    (src1[gi][W-1:0]),
      .mul_itag_i    (itag[gi]),
      .mul_res_vld_o (vld[gi]),
      .mul_res_o     (res_w),
      .mul_itag_o    (otag[gi])
    );
    assign res[gi] = 64'(res_w);
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] wmask(input int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  // Exact product using wide signed integers, then the requested half
  function automatic logic [63:0] ref_mul(input int w, input logic [1:0] o,
                                          input logic [63:0] x, input logic [63:0] y);
    logic signed [129:0] sx, sy, p;
    logic [129:0] sh;
    sx = $signed({66'd0, x & wmask(w)});
    sy = $signed({66'd0, y & wmask(w)});
    if ((o == 2'b01 || o == 2'b10) && x[w-1]) sx = sx - (130'sd1 <<< w);
    if ((o == 2'b01) && y[w-1])               sy = sy - (130'sd1 <<< w);
    p  = sx * sy;
    sh = (o == 2'b00) ? p : (p >>> w);
    return sh[63:0] & wmask(w);
  endfunction

  function automatic logic [63:0] rnd_op(input int w);
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0:       v = 64'd0;
      1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
      2:       v = 64'd1 << (w - 1);
      3:       v = 64'd1;
      default: v = {$urandom(), $urandom()};
    endcase
    return v & wmask(w);
  endfunction

  // ---------------- directed helpers (instance 0) ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive0(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                        input logic [3:0] t);
    req[0] = 1'b1; opc[0] = o; src0[0] = x; src1[0] = y; itag[0] = t;
  endtask

  // Called at cycle 1 of an op; returns the cycle vld was seen (-1 if never)
  // and how many cycles rdy was high while waiting.
  task automatic wait_vld0(output int at, output int rdy_hi);
    int c;
    at = -1; rdy_hi = 0; c = 1;
    while (at < 0 && c <= 40) begin
      if (vld[0]) at = c;
      else begin
        if (rdy[0]) rdy_hi++;
        tick();
        c++;
      end
    end
  endtask

  int          at, rh, n;
  int          vc [2];
  logic [3:0]  vt [2];
  logic [63:0] vr [2];
  logic [1:0]  d_o;
  logic [63:0] d_x, d_y, d_e;

  // random-phase model state
  bit          pv   [NC];
  logic [63:0] pres [NC];
  logic [3:0]  ptag [NC];
  int          pdue [NC];
  logic [63:0] lres [NC];
  logic [3:0]  ltag [NC];
  bit          hold [NC];
  bit          er, ev;

  localparam int T_RND   = 2500;
  localparam int T_DRAIN = 100;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NC; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; kill[i] = 1'b0; opc[i] = 2'b00;
      src0[i] = '0; src1[i] = '0; itag[i] = '0;
    end
    repeat (3) tick();
    rst[0] = 1'b0;
    tick();

    // reset state
    chk("rst_rdy",  64'(rdy[0]), 64'd1);
    chk("rst_vld",  64'(vld[0]), 64'd0);
    chk("rst_res",  res[0], 64'd0);
    chk("rst_itag", 64'(otag[0]), 64'd0);

    // model pinned by hand-computed values
    chk("model_mul",   ref_mul(32, 2'b00, 64'd7, 64'hFFFF_FFFD), 64'hFFFF_FFEB);
    chk("model_mulh",  ref_mul(32, 2'b01, 64'h8000_0000, 64'h8000_0000), 64'h4000_0000);
    chk("model_mulhu", ref_mul(64, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2), 64'd1);

    // MUL 7 * -3, tag 3: vld exactly in cycle 10, rdy low in 1..9
    drive0(2'b00, 64'd7, 64'hFFFF_FFFD, 4'd3);
    chk("t1_rdy_acc", 64'(rdy[0]), 64'd1);
    tick(); req[0] = 1'b0;
    wait_vld0(at, rh);
    chk("t1_latency", 64'(at), 64'd10);
    chk("t1_rdy_busy", 64'(rh), 64'd0);
    chk("t1_res", res[0], 64'hFFFF_FFEB);
    chk("t1_itag", 64'(otag[0]), 64'd3);
    chk("t1_rdy_done", 64'(rdy[0]), 64'd1);
    tick();
    chk("t1_vld_pulse", 64'(vld[0]), 64'd0);

    // high-half opcodes with extreme operands
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin d_o = 2'b01; d_x = 64'h8000_0000; d_y = 64'h8000_0000; d_e = 64'h4000_0000; end
        1: begin d_o = 2'b10; d_x = 64'hFFFF_FFFF; d_y = 64'hFFFF_FFFF; d_e = 64'hFFFF_FFFF; end
        default: begin d_o = 2'b11; d_x = 64'hFFFF_FFFF; d_y = 64'hFFFF_FFFF; d_e = 64'hFFFF_FFFE; end
      endcase
      drive0(d_o, d_x, d_y, 4'(k + 1));
      tick(); req[0] = 1'b0;
      wait_vld0(at, rh);
      chk($sformatf("hi%0d_latency", k), 64'(at), 64'd10);
      chk($sformatf("hi%0d_res", k), res[0], d_e);
      chk($sformatf("hi%0d_itag", k), 64'(otag[0]), 64'(k + 1));
      tick();
    end

    // back-to-back: second request held, accepted in DONE of the first
    drive0(2'b00, 64'd3, 64'd5, 4'd5);
    tick();
    drive0(2'b00, 64'd6, 64'd7, 4'd6);
    n = 0; vc[0] = -1; vc[1] = -1; vt[0] = '0; vt[1] = '0; vr[0] = '0; vr[1] = '0;
    for (int c = 1; c <= 25; c++) begin
      if (c == 11) req[0] = 1'b0;
      if (vld[0] && n < 2) begin vc[n] = c; vt[n] = otag[0]; vr[n] = res[0]; n++; end
      tick();
    end
    chk("bb_count", 64'(n), 64'd2);
    chk("bb_cyc0", 64'(vc[0]), 64'd10);
    chk("bb_cyc1", 64'(vc[1]), 64'd20);
    chk("bb_tag0", 64'(vt[0]), 64'd5);
    chk("bb_tag1", 64'(vt[1]), 64'd6);
    chk("bb_res0", vr[0], 64'd15);
    chk("bb_res1", vr[1], 64'd42);

    // kill in cycle 5: no result, ready next cycle, outputs hold
    drive0(2'b11, 64'h1234, 64'h5678, 4'd7);
    tick(); req[0] = 1'b0;
    repeat (4) tick();
    kill[0] = 1'b1;
    tick(); kill[0] = 1'b0;
    chk("kill_rdy", 64'(rdy[0]), 64'd1);
    n = 0;
    for (int c = 0; c < 15; c++) begin
      if (vld[0]) n++;
      tick();
    end
    chk("kill_no_vld", 64'(n), 64'd0);
    chk("kill_res_hold", res[0], 64'd42);
    chk("kill_itag_hold", 64'(otag[0]), 64'd6);

    // kill coinciding with accept from IDLE does not affect the new op
    drive0(2'b01, 64'hFFFF_FFFE, 64'd3, 4'd8);
    kill[0] = 1'b1;
    tick(); kill[0] = 1'b0; req[0] = 1'b0;
    wait_vld0(at, rh);
    chk("killacc_latency", 64'(at), 64'd10);
    chk("killacc_res", res[0], 64'hFFFF_FFFF);
    chk("killacc_itag", 64'(otag[0]), 64'd8);
    tick();

    // kill in DONE masks that result; request in same cycle still runs
    drive0(2'b00, 64'd2, 64'd3, 4'd9);
    tick();
    drive0(2'b00, 64'd4, 64'd5, 4'd10);
    n = 0; vc[0] = -1; vt[0] = '0; vr[0] = '0;
    for (int c = 1; c <= 25; c++) begin
      if (c == 10) begin kill[0] = 1'b1; #1; end
      if (c == 11) begin kill[0] = 1'b0; req[0] = 1'b0; end
      if (vld[0]) begin
        if (n == 0) begin vc[0] = c; vt[0] = otag[0]; vr[0] = res[0]; end
        n++;
      end
      tick();
    end
    chk("donekill_count", 64'(n), 64'd1);
    chk("donekill_cyc", 64'(vc[0]), 64'd20);
    chk("donekill_tag", 64'(vt[0]), 64'd10);
    chk("donekill_res", vr[0], 64'd20);

    // reset in cycle 4 of an op
    drive0(2'b11, 64'hFFFF_FFFF, 64'd2, 4'd11);
    tick(); req[0] = 1'b0;
    repeat (3) tick();
    rst[0] = 1'b1;
    tick(); rst[0] = 1'b0;
    chk("rstop_rdy",  64'(rdy[0]), 64'd1);
    chk("rstop_vld",  64'(vld[0]), 64'd0);
    chk("rstop_res",  res[0], 64'd0);
    chk("rstop_itag", 64'(otag[0]), 64'd0);
    n = 0;
    for (int c = 0; c < 15; c++) begin
      if (vld[0]) n++;
      tick();
    end
    chk("rstop_no_vld", 64'(n), 64'd0);

    // ---------------- randomized phase on every configuration ----------------
    for (int i = 0; i < NC; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; kill[i] = 1'b0;
      pv[i] = 1'b0; pres[i] = '0; ptag[i] = '0; pdue[i] = 0;
      lres[i] = '0; ltag[i] = '0; hold[i] = 1'b0;
    end
    repeat (2) tick();
    for (int i = 0; i < NC; i++) rst[i] = 1'b0;

    for (int t = 0; t < T_RND + T_DRAIN; t++) begin
      for (int i = 0; i < NC; i++) begin
        er = !pv[i] || (pdue[i] == t);
        ev = pv[i] && (pdue[i] == t);
        chk($sformatf("rnd%0d_rdy", i), 64'(rdy[i]), 64'(er));
        chk($sformatf("rnd%0d_vld", i), 64'(vld[i]), 64'(ev));
        if (ev) begin
          lres[i] = pres[i]; ltag[i] = ptag[i]; pv[i] = 1'b0;
        end
        chk($sformatf("rnd%0d_res", i), res[i], lres[i]);
        chk($sformatf("rnd%0d_itag", i), 64'(otag[i]), 64'(ltag[i]));

        if (!hold[i]) begin
          if (t < T_RND && $urandom_range(0, 3) != 0) begin
            req[i]  = 1'b1;
            opc[i]  = 2'($urandom_range(0, 3));
            src0[i] = rnd_op(cfg_w(i));
            src1[i] = rnd_op(cfg_w(i));
            itag[i] = 4'($urandom());
            hold[i] = 1'b1;
          end else begin
            req[i] = 1'b0;
          end
        end
        if (req[i] && er) begin
          pv[i]   = 1'b1;
          pres[i] = ref_mul(cfg_w(i), opc[i], src0[i], src1[i]);
          ptag[i] = itag[i];
          pdue[i] = t + cfg_n(i) + 2;
          hold[i] = 1'b0;
        end
      end
      tick();
    end

    for (int i = 0; i < NC; i++) begin
      chk($sformatf("rnd%0d_drained", i), 64'(pv[i]), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_xrv1_mul_iter
`default_nettype wire
